// File: rtl/mp_lut_coeff_loader_pkg.sv
// mp_lut_coeff_loader_pkg: shared width helpers and FSM encoding for the MP LUT coefficient path
package mp_lut_coeff_loader_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic int coeff_width(input int resolution);
        return $clog2(resolution);
    endfunction

    function automatic int lutnum_width(input int lut_num);
        return $clog2(lut_num);
    endfunction

    function automatic int addr_w(input int resolution, input int lut_num);
        return coeff_width(resolution) + lutnum_width(lut_num) + 2;
    endfunction
endpackage

// File: rtl/mp_lut_coeff_loader_if.sv
// mp_lut_coeff_loader_if: 32-bit valid/ready/last coefficient word stream
interface mp_lut_coeff_loader_if;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    modport master(output s_tdata, s_tvalid, s_tlast, input s_tready);
    modport slave(input s_tdata, s_tvalid, s_tlast, output s_tready);
endinterface

// File: rtl/mp_lut_coeff_loader_addr_cnt.sv
// mp_lut_coeff_loader_addr_cnt: LUT-major/entry-minor address counter with final-word flag
module mp_lut_coeff_loader_addr_cnt #(
    parameter int EW = 12,
    parameter int LW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic          i_inc,
    input  logic [LW-1:0] i_lut,
    input  logic [LW-1:0] i_last_lut,
    output logic [EW-1:0] o_entry,
    output logic [LW-1:0] o_lut,
    output logic          o_last
);
    logic [EW-1:0] r_entry;
    logic [LW-1:0] r_lut;
    logic [LW-1:0] r_last_lut;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_entry    <= '0;
            r_lut      <= '0;
            r_last_lut <= '0;
        end else if (i_load) begin
            r_entry    <= '0;
            r_lut      <= i_lut;
            r_last_lut <= i_last_lut;
        end else if (i_inc) begin
            r_entry <= r_entry + 1'b1;
            r_lut   <= r_lut + LW'(&r_entry);
        end
    end

    assign o_entry = r_entry;
    assign o_lut   = r_lut;
    assign o_last  = (&r_entry) && (r_lut == r_last_lut);
endmodule

// File: rtl/mp_lut_coeff_loader.sv
// mp_lut_coeff_loader: streams coefficient words into the MP LUT BRAM write port with framing checks
module mp_lut_coeff_loader
    import mp_lut_coeff_loader_pkg::*;
#(
    parameter int M          = 3,
    parameter int LUT_num    = M + 1,
    parameter int RESOLUTION = 4096,
    parameter int ADDR_W     = addr_w(RESOLUTION, LUT_num)
) (
    input  logic                        AXI_clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic                        single_i,
    input  logic [$clog2(LUT_num)-1:0]  lut_sel_i,
    mp_lut_coeff_loader_if.slave        s_axis,
    output logic [31:0]                 coeff_o,
    output logic [ADDR_W-1:0]           coeff_addr_o,
    output logic                        coeff_en_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o
);
    localparam int EW = coeff_width(RESOLUTION);
    localparam int LW = lutnum_width(LUT_num);

    logic [1:0]        r_state;
    logic [31:0]       r_coeff;
    logic [ADDR_W-1:0] r_addr;
    logic              r_en;
    logic              r_err;
    logic [EW-1:0]     w_entry;
    logic [LW-1:0]     w_lut;
    logic              w_last;
    logic              w_go;
    logic              w_sel_bad;
    logic              w_accept;
    logic              w_end;
    logic              w_ok;

    assign s_axis.s_tready = (r_state == S_LOAD);
    assign w_accept  = s_axis.s_tvalid && (r_state == S_LOAD);
    assign w_go      = start_i && (r_state == S_IDLE);
    assign w_sel_bad = single_i && ({1'b0, lut_sel_i} >= (LW+1)'(LUT_num));
    // A load ends on the final word or on an early tlast; only both together is clean
    assign w_end     = w_accept && (w_last || s_axis.s_tlast);
    assign w_ok      = w_last && s_axis.s_tlast;

    mp_lut_coeff_loader_addr_cnt #(.EW(EW), .LW(LW)) u_cnt (
        .i_clk      (AXI_clk_i),
        .i_rst      (reset_i),
        .i_load     (w_go && !w_sel_bad),
        .i_inc      (w_accept),
        .i_lut      (single_i ? lut_sel_i : '0),
        .i_last_lut (single_i ? lut_sel_i : LW'(LUT_num - 1)),
        .o_entry    (w_entry),
        .o_lut      (w_lut),
        .o_last     (w_last)
    );

    always_ff @(posedge AXI_clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_coeff <= '0;
            r_addr  <= '0;
            r_en    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_en <= w_accept;
            if (w_accept) begin
                r_coeff <= s_axis.s_tdata;
                r_addr  <= ADDR_W'({w_lut, w_entry, 2'b00});
            end
            if (w_go) begin
                r_err   <= w_sel_bad;
                r_state <= w_sel_bad ? S_IDLE : S_LOAD;
            end else if (w_end) begin
                r_err   <= !w_ok;
                r_state <= w_ok ? S_DONE : S_IDLE;
            end else if (r_state == S_DONE) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign coeff_o      = r_coeff;
    assign coeff_addr_o = r_addr;
    assign coeff_en_o   = r_en;
    assign busy_o       = (r_state == S_LOAD);
    assign done_o       = (r_state == S_DONE);
    assign err_o        = r_err;
endmodule

// File: tb/tb_mp_lut_coeff_loader.sv
// tb_mp_lut_coeff_loader: randomized scenario bench against a word-list reference model
module tb_mp_lut_coeff_loader;
    localparam int RES  = 16;
    localparam int LUTS = 4;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       start_i = 1'b0;
    logic       single_i = 1'b0;
    logic [1:0] lut_sel_i = '0;
    logic [31:0] coeff_o;
    logic [7:0]  coeff_addr_o;
    logic        coeff_en_o, busy_o, done_o, err_o;
    int errs = 0;
    int checks = 0;

    mp_lut_coeff_loader_if bus();

    mp_lut_coeff_loader #(.M(3), .RESOLUTION(RES)) dut (
        .AXI_clk_i    (clk),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .single_i     (single_i),
        .lut_sel_i    (lut_sel_i),
        .s_axis       (bus.slave),
        .coeff_o      (coeff_o),
        .coeff_addr_o (coeff_addr_o),
        .coeff_en_o   (coeff_en_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check_idle_zero(input string tag);
        checks++; if (coeff_o !== 32'h0) begin errs++; $display("FAIL %s coeff_o got=%h exp=0", tag, coeff_o); end
        checks++; if (coeff_addr_o !== 8'h0) begin errs++; $display("FAIL %s addr got=%h exp=0", tag, coeff_addr_o); end
        checks++; if (coeff_en_o !== 1'b0) begin errs++; $display("FAIL %s en got=%b exp=0", tag, coeff_en_o); end
        checks++; if (busy_o !== 1'b0) begin errs++; $display("FAIL %s busy got=%b exp=0", tag, busy_o); end
        checks++; if (done_o !== 1'b0) begin errs++; $display("FAIL %s done got=%b exp=0", tag, done_o); end
        checks++; if (err_o !== 1'b0) begin errs++; $display("FAIL %s err got=%b exp=0", tag, err_o); end
        checks++; if (bus.s_tready !== 1'b0) begin errs++; $display("FAIL %s ready got=%b exp=0", tag, bus.s_tready); end
    endtask

    task automatic do_start(input bit single, input int sel);
        start_i   = 1'b1;
        single_i  = single;
        lut_sel_i = 2'(sel);
        @(negedge clk);
        start_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errs++; $display("FAIL start busy got=%b exp=1", busy_o); end
        checks++; if (err_o !== 1'b0) begin errs++; $display("FAIL start err_clear got=%b exp=0", err_o); end
    endtask

    // Expected writes are word k at byte address (first_lut*RES + k)*4, stopping at tlast or the span end
    task automatic run_load(input string tag, input bit single, input int sel, input int nwords,
                            input int tlast_at, input int gap);
        int total, base, stop_at, acc, k, pend_k, post, cyc;
        bit pend, done_exp, v;
        logic [31:0] w[$];
        total    = single ? RES : RES * LUTS;
        base     = single ? sel * RES : 0;
        stop_at  = (tlast_at >= 0 && tlast_at < total - 1) ? tlast_at : total - 1;
        acc      = (nwords < stop_at + 1) ? nwords : stop_at + 1;
        done_exp = (tlast_at == total - 1) && (acc == total);
        for (int i = 0; i < nwords; i++) w.push_back($urandom);
        do_start(single, sel);
        k = 0; pend = 0; pend_k = 0; post = 0; cyc = 0;
        while (post < 4 && cyc < 3000) begin
            checks++; if (coeff_en_o !== pend) begin errs++; $display("FAIL %s en cyc=%0d got=%b exp=%b", tag, cyc, coeff_en_o, pend); end
            checks++; if (done_o !== (pend && pend_k == stop_at && done_exp)) begin errs++; $display("FAIL %s done cyc=%0d got=%b", tag, cyc, done_o); end
            if (pend) begin
                checks++; if (coeff_addr_o !== 8'((base + pend_k) * 4)) begin errs++; $display("FAIL %s addr word=%0d got=%h exp=%h", tag, pend_k, coeff_addr_o, 8'((base + pend_k) * 4)); end
                checks++; if (coeff_o !== w[pend_k]) begin errs++; $display("FAIL %s data word=%0d got=%h exp=%h", tag, pend_k, coeff_o, w[pend_k]); end
            end
            checks++; if (bus.s_tready !== (k < acc)) begin errs++; $display("FAIL %s ready cyc=%0d got=%b exp=%b", tag, cyc, bus.s_tready, k < acc); end
            v = (k < nwords) && ($urandom_range(99) >= gap);
            bus.s_tvalid = v;
            bus.s_tdata  = (k < nwords) ? w[k] : 32'h0;
            bus.s_tlast  = v && (k == tlast_at);
            pend = v && (k < acc);
            if (pend) begin pend_k = k; k++; end
            if (k == acc && !pend) post++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 3000) begin checks++; errs++; $display("FAIL %s timeout got=%0d words exp=%0d", tag, k, acc); end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        checks++; if (err_o !== !done_exp) begin errs++; $display("FAIL %s err got=%b exp=%b", tag, err_o, !done_exp); end
        checks++; if (busy_o !== 1'b0) begin errs++; $display("FAIL %s busy_end got=%b exp=0", tag, busy_o); end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        run_load("full", 1'b0, 0, 64, 63, 0);
    endtask

    task automatic test_single_gaps();
        run_load("single_gaps", 1'b1, 2, 16, 15, 30);
    endtask

    task automatic test_early_tlast();
        run_load("early_tlast", 1'b1, 1, 16, 5, 0);
    endtask

    task automatic test_missing_tlast();
        run_load("missing_tlast", 1'b0, 0, 65, -1, 0);
    endtask

    task automatic test_restart_and_reset();
        do_start(1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin
                checks++; if (coeff_en_o !== 1'b1) begin errs++; $display("FAIL restart en word=%0d got=%b exp=1", i - 1, coeff_en_o); end
                checks++; if (coeff_addr_o !== 8'((i - 1) * 4)) begin errs++; $display("FAIL restart addr word=%0d got=%h exp=%h", i - 1, coeff_addr_o, 8'((i - 1) * 4)); end
            end
            bus.s_tvalid = (i < 11);
            bus.s_tdata  = $urandom;
            bus.s_tlast  = 1'b0;
            start_i   = (i == 5);
            single_i  = (i == 5);
            lut_sel_i = 2'd3;
            @(negedge clk);
        end
        start_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errs++; $display("FAIL restart busy got=%b exp=1", busy_o); end
        checks++; if (err_o !== 1'b0) begin errs++; $display("FAIL restart err got=%b exp=0", err_o); end
        reset_i = 1'b1;
        @(negedge clk);
        check_idle_zero("midload_reset");
        reset_i = 1'b0;
        @(negedge clk);
        run_load("after_reset", 1'b0, 0, 64, 63, 20);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 3; n++) run_load("b2b", 1'b1, int'($urandom_range(3)), 16, 15, 15);
    endtask

    initial begin
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.s_tdata  = '0;
        @(negedge clk);
        test_reset();
        test_full_load();
        test_single_gaps();
        test_early_tlast();
        test_missing_tlast();
        test_restart_and_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
